add_pipe_rca: RTL and testbench
===============================

# add_pipe_rca

Parametrised, pipelined ripple-carry adder. It adds two WIDTH-bit operands plus a carry-in. The carry chain is split into CHUNK-bit slices, with one slice evaluated per clock stage. It replaces fixed-width combinational adders on datapaths where the full ripple does not close timing. A valid/ready handshake on both sides lets it sit directly between streaming producers and consumers.

## Interface
- WIDTH, 16: operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline stage. Must satisfy 1 ≤ CHUNK ≤ WIDTH.
- Derived: STAGES = WIDTH/CHUNK. This is a localparam, not overridable.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operands and carry-in present this cycle.
- in_ready, output, 1: block accepts the transaction when in_valid && in_ready.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- c_in, input, 1: carry into bit 0.
- out_valid, output, 1: sum, c_out and ovf are valid.
- out_ready, input, 1: consumer accepts the result when out_valid && out_ready.
- sum, output, WIDTH: a + b + c_in, modulo 2^WIDTH.
- c_out, output, 1: carry out of bit WIDTH-1.
- ovf, output, 1: signed overflow. Present only with ADD_PIPE_OVF_EN.

## Operation
- Pipeline has STAGES register stages, indexed 0..STAGES-1. Each stage holds:
  - a valid bit;
  - the sum slices resolved so far;
  - the running carry;
  - the not-yet-added upper operand bits.
- Stage k resolves bits [k·CHUNK +: CHUNK]:
  - {carry, slice} = a_slice + b_slice + carry_prev;
  - carry_prev is c_in for stage 0, otherwise the carry held in stage k-1;
  - the slice is computed as a CHUNK-bit ripple of full adders.
- Stage advance uses a global enable: adv = !out_valid || out_ready.
  - When adv = 1, every stage loads from its predecessor.
  - Stage 0 loads from the input port; its valid = in_valid.
  - When adv = 0, all stages hold their contents.
- in_ready = adv, combinational from out_valid and out_ready.
  - Bubbles are not squeezed out; an empty stage still shifts only on adv.
- Outputs are driven directly from the last stage registers:
  - out_valid = valid[STAGES-1];
  - sum = the full resolved vector;
  - c_out = the final carry.
- The arithmetic result is identical to the unpipelined sum for every input, including all-ones + all-ones + 1 (sum = all-ones, c_out = 1).
- Invalid stages still clock data; contents are don't-care, but they must never assert out_valid.

## Timing
- Reset (async assert) clears all valid bits and all data registers to 0:
  - out_valid = 0, sum = 0, c_out = 0, ovf = 0;
  - in_ready = 1 immediately after reset.
- Latency: a transaction accepted at edge N appears with out_valid = 1 after edge N+STAGES-1. Its first visible cycle is the one following that edge.
- Throughput: one transaction per cycle while out_ready stays 1.
- Backpressure: while out_valid = 1 and out_ready = 0:
  - in_ready = 0;
  - all outputs stay stable until the cycle out_ready rises.
- Simultaneous events: pop at the output and push at the input in the same cycle are both honoured with no dead cycle.
- Reset mid-operation: all in-flight transactions are discarded and none appears afterwards.
  - Reset release is synchronised externally; the block needs no deassert handling.
- CHUNK = WIDTH: single stage, latency 1, still registered.

## Configuration
- ADD_PIPE_OVF_EN defined:
  - the ovf port exists;
  - ovf = carry into bit WIDTH-1 XOR c_out;
  - it travels with its transaction and resets to 0.
- ADD_PIPE_OVF_EN undefined:
  - no ovf port and no related register;
  - all other behaviour is identical.

## Test plan
- Carry through every stage (WIDTH=16, CHUNK=4):
  - stimulus: a=0xFFFF, b=0x0001, c_in=0 accepted at edge 0;
  - response: out_valid=1 after edge 3 with sum=0x0000, c_out=1.
- Streaming with out_ready held 1:
  - stimulus: 100 back-to-back random transactions;
  - response: results in order, one per cycle, each matching a+b+c_in with carry.
- Backpressure:
  - stimulus: hold out_ready=0 for 5 cycles with the pipe full;
  - response: in_ready=0, outputs frozen, no loss or duplication after release.
- Reset mid-flight:
  - stimulus: 3 transactions in flight, then rst pulsed;
  - response: out_valid=0 at once and no stale result ever emerges.
- Overflow (ADD_PIPE_OVF_EN):
  - stimulus: 0x7FFF+0x0001;
  - response: sum=0x8000, ovf=1, c_out=0;
  - stimulus: 0xFFFF+0xFFFF;
  - response: sum=0xFFFE, ovf=0, c_out=1.
- Alternate parameters:
  - stimulus: WIDTH=8, CHUNK=8; 0xFF+0xFF+1;
  - response: latency 1, sum=0xFF, c_out=1.
  - stimulus: WIDTH=32, CHUNK=1; any transaction;
  - response: latency 32.

Source files
------------

// File: rtl/add_pipe_rca.sv
// add_pipe_rca: pipelined ripple-carry adder, WIDTH bits split into CHUNK-bit
// slices with one slice resolved per register stage. A valid/ready handshake
// on both sides uses a single global advance enable; bubbles are not removed.
// Optional feature macro: ADD_PIPE_OVF_EN adds the signed-overflow output ovf.
module add_pipe_rca #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = WIDTH / CHUNK;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];

    // Predecessor view of every stage: stage 0 sees the input port.
    logic [STAGES-1:0] pre_v;
    logic [STAGES-1:0] pre_c;
    logic [WIDTH-1:0]  pre_a [STAGES];
    logic [WIDTH-1:0]  pre_b [STAGES];
    logic [WIDTH-1:0]  pre_s [STAGES];

    logic [WIDTH-1:0]  work_s;
    logic              rc;
    logic              adv;
`ifdef ADD_PIPE_OVF_EN
    logic              msb_cin;
    logic              ovf_q, ovf_d;
`endif

    // Select each stage's source: input port for stage 0, previous stage otherwise.
    always_comb begin
        pre_v[0] = in_valid;
        pre_c[0] = c_in;
        pre_a[0] = a;
        pre_b[0] = b;
        pre_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            pre_v[k] = vld_q[k-1];
            pre_c[k] = cy_q[k-1];
            pre_a[k] = opa_q[k-1];
            pre_b[k] = opb_q[k-1];
            pre_s[k] = sum_q[k-1];
        end
    end

    // Resolve one slice per stage with a bit-level full-adder ripple; load on adv.
    always_comb begin
        adv    = !vld_q[STAGES-1] || out_ready;
        vld_d  = vld_q;
        cy_d   = cy_q;
        work_s = '0;
        rc     = 1'b0;
`ifdef ADD_PIPE_OVF_EN
        msb_cin = 1'b0;
        ovf_d   = ovf_q;
`endif
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = sum_q[k];
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
            work_s   = pre_s[k];
            rc       = pre_c[k];
            for (int i = 0; i < CHUNK; i++) begin
`ifdef ADD_PIPE_OVF_EN
                if (k * CHUNK + i == WIDTH - 1) msb_cin = rc;
`endif
                work_s[k*CHUNK+i] = pre_a[k][k*CHUNK+i] ^ pre_b[k][k*CHUNK+i] ^ rc;
                rc = (pre_a[k][k*CHUNK+i] & pre_b[k][k*CHUNK+i]) |
                     (rc & (pre_a[k][k*CHUNK+i] ^ pre_b[k][k*CHUNK+i]));
            end
            if (adv) begin
                vld_d[k] = pre_v[k];
                cy_d[k]  = rc;
                sum_d[k] = work_s;
                opa_d[k] = pre_a[k];
                opb_d[k] = pre_b[k];
`ifdef ADD_PIPE_OVF_EN
                // The carry into the MSB is only known once the last slice is resolved.
                if (k == STAGES - 1) ovf_d = msb_cin ^ rc;
`endif
            end
        end
    end

    // Stage registers; reset discards every in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
`ifdef ADD_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
`ifdef ADD_PIPE_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
`ifdef ADD_PIPE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_add_pipe_rca.sv
module tb_add_pipe_rca;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b1, c_in = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, c_out;
    logic [15:0] sum;

    logic        v8 = 1'b0, c8 = 1'b0, rdy8_in, ov8, co8;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        v32 = 1'b0, c32 = 1'b0, rdy32_in, ov32, co32;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        one = 1'b1;

`ifdef ADD_PIPE_OVF_EN
    logic ovf, ovf8, ovf32;
    logic m_o [4];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: four-deep latency line of full-precision sums.
    logic        m_v [4];
    logic [16:0] m_r [4];
    int          n_push, n_pop;

    add_pipe_rca #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef ADD_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    add_pipe_rca #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8_in),
        .a(a8), .b(b8), .c_in(c8), .out_valid(ov8), .out_ready(one),
        .sum(s8), .c_out(co8)
`ifdef ADD_PIPE_OVF_EN
        , .ovf(ovf8)
`endif
    );

    add_pipe_rca #(.WIDTH(32), .CHUNK(1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32_in),
        .a(a32), .b(b32), .c_in(c32), .out_valid(ov32), .out_ready(one),
        .sum(s32), .c_out(co32)
`ifdef ADD_PIPE_OVF_EN
        , .ovf(ovf32)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_v[k] = 1'b0;
            m_r[k] = '0;
`ifdef ADD_PIPE_OVF_EN
            m_o[k] = 1'b0;
`endif
        end
        n_push = 0;
        n_pop  = 0;
    endtask

    // Advance the model by one clock using the current port inputs.
    task automatic model_step();
        if (!m_v[3] || out_ready) begin
            if (m_v[3]) n_pop++;
            for (int k = 3; k > 0; k--) begin
                m_v[k] = m_v[k-1];
                m_r[k] = m_r[k-1];
`ifdef ADD_PIPE_OVF_EN
                m_o[k] = m_o[k-1];
`endif
            end
            m_v[0] = in_valid;
            m_r[0] = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
`ifdef ADD_PIPE_OVF_EN
            m_o[0] = (a[15] == b[15]) && (m_r[0][15] != a[15]);
`endif
            if (in_valid) n_push++;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_chk++; if (sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0000", sum); end
        n_chk++; if (c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out got %0b want 0", c_out); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
`ifdef ADD_PIPE_OVF_EN
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
`endif
        do_reset();
    endtask

    task automatic test_carry_chain();
        do_reset();
        a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            n_chk++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL carry_latency edge %0d got out_valid %0b want 0", e - 1, out_valid); end
            @(posedge clk); #1;
        end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL carry_valid got %0b want 1", out_valid); end
        n_chk++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL carry_sum got %h want 0000", sum); end
        n_chk++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL carry_c_out got %0b want 1", c_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 108; i++) begin
            in_valid = (i < 100); a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); out_ready = 1'b1;
            #1;
            n_chk++;
            if (out_valid !== m_v[3]) begin n_fail++; $display("FAIL stream_valid cyc %0d got %0b want %0b", i, out_valid, m_v[3]); end
            n_chk++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc %0d got %0b want 1", i, in_ready); end
            if (m_v[3]) begin
                n_chk++;
                if ({c_out, sum} !== m_r[3]) begin n_fail++; $display("FAIL stream_result cyc %0d got %0b_%h want %0b_%h", i, c_out, sum, m_r[3][16], m_r[3][15:0]); end
`ifdef ADD_PIPE_OVF_EN
                n_chk++;
                if (ovf !== m_o[3]) begin n_fail++; $display("FAIL stream_ovf cyc %0d got %0b want %0b", i, ovf, m_o[3]); end
`endif
            end
            model_step();
            @(posedge clk); #1;
        end
        n_chk++;
        if (n_pop !== 100) begin n_fail++; $display("FAIL stream_count got %0d want 100", n_pop); end
    endtask

    task automatic test_backpressure();
        logic [15:0] held_sum;
        logic        held_c;
        held_sum = '0;
        held_c   = 1'b0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            in_valid  = (i < 9);
            out_ready = !(i >= 4 && i < 9);
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
            #1;
            n_chk++;
            if (out_valid !== m_v[3]) begin n_fail++; $display("FAIL bp_valid cyc %0d got %0b want %0b", i, out_valid, m_v[3]); end
            n_chk++;
            if (in_ready !== (!m_v[3] || out_ready)) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %0b want %0b", i, in_ready, !m_v[3] || out_ready); end
            if (m_v[3]) begin
                n_chk++;
                if ({c_out, sum} !== m_r[3]) begin n_fail++; $display("FAIL bp_result cyc %0d got %0b_%h want %0b_%h", i, c_out, sum, m_r[3][16], m_r[3][15:0]); end
`ifdef ADD_PIPE_OVF_EN
                n_chk++;
                if (ovf !== m_o[3]) begin n_fail++; $display("FAIL bp_ovf cyc %0d got %0b want %0b", i, ovf, m_o[3]); end
`endif
            end
            if (i == 4) begin held_sum = sum; held_c = c_out; end
            if (i > 4 && i < 9) begin
                n_chk++;
                if (sum !== held_sum || c_out !== held_c) begin n_fail++; $display("FAIL bp_frozen cyc %0d got %0b_%h want %0b_%h", i, c_out, sum, held_c, held_sum); end
            end
            model_step();
            @(posedge clk); #1;
        end
        n_chk++;
        if (n_pop !== 4 || n_push !== 4) begin n_fail++; $display("FAIL bp_count got pushed %0d popped %0d want 4 4", n_push, n_pop); end
    endtask

    task automatic test_random_handshake();
        do_reset();
        for (int i = 0; i < 230; i++) begin
            in_valid  = (i < 200) && ($urandom_range(99) < 70);
            out_ready = (i >= 200) || ($urandom_range(99) < 60);
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
            if (i == 50) begin a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; end
            #1;
            n_chk++;
            if (out_valid !== m_v[3]) begin n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", i, out_valid, m_v[3]); end
            n_chk++;
            if (in_ready !== (!m_v[3] || out_ready)) begin n_fail++; $display("FAIL rand_in_ready cyc %0d got %0b want %0b", i, in_ready, !m_v[3] || out_ready); end
            if (m_v[3]) begin
                n_chk++;
                if ({c_out, sum} !== m_r[3]) begin n_fail++; $display("FAIL rand_result cyc %0d got %0b_%h want %0b_%h", i, c_out, sum, m_r[3][16], m_r[3][15:0]); end
`ifdef ADD_PIPE_OVF_EN
                n_chk++;
                if (ovf !== m_o[3]) begin n_fail++; $display("FAIL rand_ovf cyc %0d got %0b want %0b", i, ovf, m_o[3]); end
`endif
            end
            model_step();
            @(posedge clk); #1;
        end
        n_chk++;
        if (n_pop !== n_push) begin n_fail++; $display("FAIL rand_count got popped %0d want %0d", n_pop, n_push); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full got out_valid %0b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drop got out_valid %0b want 0", out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cyc %0d got out_valid %0b want 0", i, out_valid); end
            @(posedge clk); #1;
        end
    endtask

`ifdef ADD_PIPE_OVF_EN
    task automatic test_ovf();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; c_in = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1 || sum !== 16'h8000 || c_out !== 1'b0 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_pos got v%0b %h c%0b o%0b want v1 8000 c0 o1", out_valid, sum, c_out, ovf); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1 || sum !== 16'hFFFE || c_out !== 1'b1 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_neg got v%0b %h c%0b o%0b want v1 fffe c1 o0", out_valid, sum, c_out, ovf); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_alt_params();
        int          cnt;
        logic [32:0] exp32;
        do_reset();
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
        #1;
        n_chk++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL w8_pre got out_valid %0b want 0", ov8); end
        @(posedge clk); #1;
        v8 = 1'b0;
        n_chk++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL w8_latency got out_valid %0b want 1", ov8); end
        n_chk++; if (s8 !== 8'hFF || co8 !== 1'b1) begin n_fail++; $display("FAIL w8_result got %0b_%h want 1_ff", co8, s8); end
        @(posedge clk); #1;

        a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
        exp32 = {1'b0, a32} + {1'b0, b32} + {32'd0, c32};
        v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        cnt = 1;
        while (ov32 !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_chk++; if (cnt !== 32) begin n_fail++; $display("FAIL w32_latency got %0d edges want 32", cnt); end
        n_chk++; if ({co32, s32} !== exp32) begin n_fail++; $display("FAIL w32_result got %0b_%h want %0b_%h", co32, s32, exp32[32], exp32[31:0]); end
        @(posedge clk); #1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_carry_chain();
        test_stream();
        test_backpressure();
        test_random_handshake();
        test_reset_midflight();
`ifdef ADD_PIPE_OVF_EN
        test_ovf();
`endif
        test_alt_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
